// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// mux_pkg : constants shared by the TDM transmit sequencer and tdm_demux
// Revision: 1.0
// ============================================================================
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [SLOT_W-1:0] CH_A = 2'd0;
  localparam logic [SLOT_W-1:0] CH_B = 2'd1;
  localparam logic [SLOT_W-1:0] CH_C = 2'd2;
  localparam logic [SLOT_W-1:0] CH_D = 2'd3;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SLOT_W-1:0] idx);
    ch_onehot = NUM_CH'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_demux_slot_counter.sv
`default_nettype none
// ============================================================================
// slot_counter : cycle-within-slot and slot-within-frame counters
// Revision: 1.0
// ============================================================================
module slot_counter
  import mux_pkg::*;
#(
  parameter int SLOT_CYCLES  = 8,
  parameter int SAMPLE_POINT = 4,
  localparam int CNT_W       = $clog2(SLOT_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic [CNT_W-1:0]  cnt,
  output logic [SLOT_W-1:0] slot,
  output logic              at_sample,
  output logic              at_boundary
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SMP  = CNT_W'(SAMPLE_POINT);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_CH - 1);

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (clr) begin
      cnt_d  = '0;
      slot_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      slot_d = slot_q + 1'b1;  // NUM_CH is a power of two, so 3 wraps to 0
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  assign cnt         = cnt_q;
  assign slot        = slot_q;
  assign at_sample   = (cnt_q == CNT_SMP);
  assign at_boundary = (cnt_q == CNT_MAX) && (slot_q == SLOT_MAX);

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// tdm_demux : recovers four 1-bit channels from a sync-aligned TDM line
// Revision: 1.0
// ============================================================================
module tdm_demux
  import mux_pkg::*;
#(
  parameter int SLOT_CYCLES  = 8,
  parameter int SAMPLE_POINT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              sync,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic [SLOT_W-1:0] sel,
  output logic [NUM_CH-1:0] ch_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);

  logic [0:0]        state_q, state_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_err_q, sync_err_d;

  logic              run;
  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] slot;
  logic              at_sample;
  logic              at_boundary;
  logic              unused_cnt;

  assign run        = (state_q == ST_RUN);
  assign unused_cnt = ^cnt;

  // Counters sit at zero while idle and restart from zero on every sync.
  slot_counter #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_slot_counter (
    .clk         (clk),
    .rst         (rst),
    .clr         (sync || !run),
    .cnt         (cnt),
    .slot        (slot),
    .at_sample   (at_sample),
    .at_boundary (at_boundary)
  );

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (run) begin
      // The pre-sync slot still decides the channel when sync hits a sample point.
      if (at_sample) begin
        ch_d[slot] = din;
        ch_valid_d = ch_onehot(slot);
      end
      frame_done_d = at_boundary;
      sync_err_d   = sync && !at_boundary;
    end else if (sync) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign a          = ch_q[CH_A];
  assign b          = ch_q[CH_B];
  assign c          = ch_q[CH_C];
  assign d          = ch_q[CH_D];
  assign sel        = slot;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign locked     = run;
  assign sync_err   = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// tb_tdm_demux : directed and random checks of tdm_demux against a frame-position model
// Revision: 1.0
// ============================================================================
module tb_tdm_demux;

  localparam int SC    = 8;
  localparam int SP    = 4;
  localparam int FRAME = 4 * SC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic       a, b, c, d;
  logic [1:0] sel;
  logic [3:0] ch_valid;
  logic       frame_done, locked, sync_err;

  tdm_demux #(.SLOT_CYCLES(SC), .SAMPLE_POINT(SP)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .sync       (sync),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .sel        (sel),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int base = 0;

  // Model: whether locked, the cycle of the last accepted sync, held channel values.
  bit         m_locked = 1'b0;
  int         m_t = 0;
  logic [3:0] m_ch = 4'b0;

  function automatic int model_slot();
    return ((cyc - m_t - 1) % FRAME) / SC;
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc - base, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the registered outputs, clock, and compare.
  task automatic tick(input logic r, input logic s, input logic dn);
    logic [3:0]  ev;
    logic        efd, eerr;
    logic [1:0]  esel;
    int          p;
    rst  = r;
    sync = s;
    din  = dn;
    ev   = 4'b0;
    efd  = 1'b0;
    eerr = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_ch     = 4'b0;
    end else if (!m_locked) begin
      if (s) begin
        m_locked = 1'b1;
        m_t      = cyc;
      end
    end else begin
      p = (cyc - m_t - 1) % FRAME;
      if (p % SC == SP) begin
        m_ch[p / SC] = dn;
        ev[p / SC]   = 1'b1;
      end
      efd  = (p == FRAME - 1);
      eerr = s && (p != FRAME - 1);
      if (s) m_t = cyc;
    end
    esel = m_locked ? 2'(((cyc - m_t) % FRAME) / SC) : 2'd0;
    @(posedge clk);
    #1;
    cyc++;
    chk("model", {d, c, b, a, sel, ch_valid, frame_done, locked, sync_err},
        {m_ch, esel, ev, efd, m_locked, eerr});
  endtask

  task automatic restart();
    tick(1'b1, 1'b0, 1'b0);
    base = cyc - 1;
  endtask

  initial begin
    logic [3:0] pat;
    int         sc;

    // Basic frame, free-run and pre-sync idle behaviour.
    restart();
    for (int n = 1; n <= 76; n++) begin
      pat = (n < 43) ? 4'b1101 : 4'b0010;
      tick(1'b0, n == 10, (n > 10) ? pat[model_slot()] : 1'($urandom));
      sc = cyc - base;
      if (sc <= 10) chk("presync_idle", {ch_valid, locked}, 5'b0);
      if (sc == 11) chk("locked_at_11", 13'(locked), 13'd1);
      if (sc == 16 || sc == 24 || sc == 32 || sc == 40)
        chk("ch_valid_frame1", 13'(ch_valid), 13'(4'b0001 << ((sc - 16) / SC)));
      if (sc == 42) chk("chan_frame1", {d, c, b, a}, 13'b1101);
      if (sc == 43 || sc == 75) chk("frame_done", 13'(frame_done), 13'd1);
      if (sc == 44) chk("frame_done_pulse", 13'(frame_done), 13'd0);
    end
    chk("chan_frame2", {d, c, b, a}, 13'b0010);

    // Mid-frame resync at slot 1, cnt 1.
    restart();
    for (int n = 1; n <= 55; n++) begin
      tick(1'b0, n == 10 || n == 20, 1'($urandom));
      sc = cyc - base;
      if (sc == 21) chk("resync_err_sel", {sync_err, sel}, 13'b100);
      if (sc == 26) chk("resync_ch_valid", 13'(ch_valid), 13'b0001);
      if (sc == 43) chk("resync_no_done", 13'(frame_done), 13'd0);
      if (sc == 53) chk("resync_done", 13'(frame_done), 13'd1);
    end

    // Sync exactly on the frame boundary.
    restart();
    for (int n = 1; n <= 50; n++) begin
      tick(1'b0, n == 10 || n == 42, 1'($urandom));
      sc = cyc - base;
      if (sc == 43) chk("bnd_done_noerr", {frame_done, sync_err}, 13'b10);
      if (sc == 48) chk("bnd_ch_valid", 13'(ch_valid), 13'b0001);
    end

    // Reset in the middle of a running frame, then no sampling without a sync.
    restart();
    for (int n = 1; n <= 60; n++) begin
      tick(n == 30, n == 10, 1'($urandom));
      sc = cyc - base;
      if (sc == 31) chk("mid_reset_zero", {d, c, b, a, sel, ch_valid, frame_done, locked, sync_err}, 13'b0);
      if (sc > 31) chk("post_reset_idle", {ch_valid, locked}, 5'b0);
    end

    // Random traffic with occasional syncs and resets.
    restart();
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
